// File: rtl/div_iter_unit_pkg.sv
// Shared definitions for the iterative divider: state encoding and default sizes.
package div_iter_unit_pkg;

   localparam int DIV_WIDTH_DEF = 32;
   localparam int CNT_W_DEF     = 6;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift {rem, dvd} left, conditionally subtract.
module div_restore_step #(
   parameter int DIV_WIDTH = 32
) (
   input  logic [DIV_WIDTH-1:0] rem,
   input  logic [DIV_WIDTH-1:0] dvd,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic [DIV_WIDTH-1:0] rem_next,
   output logic [DIV_WIDTH-1:0] dvd_next
);

   logic [DIV_WIDTH:0] shifted;
   logic               q_bit;

   always_comb begin
      shifted = {rem, dvd[DIV_WIDTH-1]};
      q_bit   = (shifted >= {1'b0, divisor});
      // With rem < divisor the difference always fits back into DIV_WIDTH bits
      rem_next = q_bit ? (shifted[DIV_WIDTH-1:0] - divisor) : shifted[DIV_WIDTH-1:0];
      dvd_next = {dvd[DIV_WIDTH-2:0], q_bit};
   end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative restoring DIV/DIVU unit for the E stage; quotient to LO, remainder to HI.
// Optional macro DIV_FAST_TRIVIAL_EN: a == 0 or b == 0 completes one cycle after latch.
module div_iter_unit
   import div_iter_unit_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 div_start,
   input  logic                 div_signed,
   input  logic [DIV_WIDTH-1:0] div_a,
   input  logic [DIV_WIDTH-1:0] div_b,
   input  logic                 div_cancel,
   output logic                 div_complete,
   output logic [DIV_WIDTH-1:0] div_q,
   output logic [DIV_WIDTH-1:0] div_r,
   output logic                 div_busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_WIDTH - 1);

   div_state_t           state_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [DIV_WIDTH-1:0] rem_reg;
   logic [DIV_WIDTH-1:0] dvd_reg;
   logic [DIV_WIDTH-1:0] dsr_reg;
   logic [DIV_WIDTH-1:0] q_reg;
   logic [DIV_WIDTH-1:0] r_reg;
   logic                 sign_q_reg;
   logic                 sign_r_reg;
   logic                 complete_reg;

   logic [DIV_WIDTH-1:0] rem_step;
   logic [DIV_WIDTH-1:0] dvd_step;
   logic [DIV_WIDTH-1:0] a_abs;
   logic [DIV_WIDTH-1:0] b_abs;
   logic [DIV_WIDTH-1:0] q_fix;
   logic [DIV_WIDTH-1:0] r_fix;
   logic                 a_neg;
   logic                 b_neg;
   logic                 b_zero;
`ifdef DIV_FAST_TRIVIAL_EN
   logic                 a_zero;
`endif

   // Divide by zero keeps the raw dividend and no sign fix, so r comes out equal to a
   always_comb begin
      b_zero = (div_b == '0);
      a_neg  = div_signed & div_a[DIV_WIDTH-1] & ~b_zero;
      b_neg  = div_signed & div_b[DIV_WIDTH-1];
      a_abs  = a_neg ? ('0 - div_a) : div_a;
      b_abs  = b_neg ? ('0 - div_b) : div_b;
      q_fix  = sign_q_reg ? ('0 - dvd_step) : dvd_step;
      r_fix  = sign_r_reg ? ('0 - rem_step) : rem_step;
   end

`ifdef DIV_FAST_TRIVIAL_EN
   assign a_zero = (div_a == '0);
`endif

   div_restore_step #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_step (
      .rem      (rem_reg),
      .dvd      (dvd_reg),
      .divisor  (dsr_reg),
      .rem_next (rem_step),
      .dvd_next (dvd_step)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= DIV_IDLE;
         cnt_reg      <= '0;
         rem_reg      <= '0;
         dvd_reg      <= '0;
         dsr_reg      <= '0;
         q_reg        <= '0;
         r_reg        <= '0;
         sign_q_reg   <= 1'b0;
         sign_r_reg   <= 1'b0;
         complete_reg <= 1'b0;
      end else begin
         complete_reg <= 1'b0;
         case (state_reg)
            DIV_IDLE: begin
               if (div_start && !div_cancel) begin
                  sign_q_reg <= div_signed & (div_a[DIV_WIDTH-1] ^ div_b[DIV_WIDTH-1]) & ~b_zero;
                  sign_r_reg <= a_neg;
                  dsr_reg    <= b_abs;
                  cnt_reg    <= '0;
`ifdef DIV_FAST_TRIVIAL_EN
                  if (b_zero || a_zero) begin
                     q_reg        <= b_zero ? '1 : '0;
                     r_reg        <= div_a;
                     complete_reg <= 1'b1;
                     state_reg    <= DIV_DONE;
                  end else begin
                     rem_reg   <= '0;
                     dvd_reg   <= a_abs;
                     state_reg <= DIV_BUSY;
                  end
`else
                  rem_reg   <= '0;
                  dvd_reg   <= a_abs;
                  state_reg <= DIV_BUSY;
`endif
               end
            end
            DIV_BUSY: begin
               if (div_cancel) begin
                  state_reg <= DIV_IDLE;
               end else begin
                  rem_reg <= rem_step;
                  dvd_reg <= dvd_step;
                  cnt_reg <= cnt_reg + 1'b1;
                  // Results are registered on the final step so they appear with the pulse
                  if (cnt_reg == LAST_CNT) begin
                     q_reg        <= q_fix;
                     r_reg        <= r_fix;
                     complete_reg <= 1'b1;
                     state_reg    <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: state_reg <= DIV_IDLE;
            default:  state_reg <= DIV_IDLE;
         endcase
      end
   end

   // A kill arriving in the DONE cycle still suppresses the pulse
   assign div_complete = complete_reg & ~div_cancel;
   assign div_q        = q_reg;
   assign div_r        = r_reg;
   assign div_busy     = (state_reg != DIV_IDLE);

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed divisions against an arithmetic reference.
module tb_div_iter_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;
`ifdef DIV_FAST_TRIVIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic         clk        = 1'b0;
   logic         reset      = 1'b1;
   logic         div_start  = 1'b0;
   logic         div_signed = 1'b0;
   logic         div_cancel = 1'b0;
   logic [W-1:0] div_a      = '0;
   logic [W-1:0] div_b      = '0;
   logic         div_complete;
   logic         div_busy;
   logic [W-1:0] div_q;
   logic [W-1:0] div_r;

   int checks   = 0;
   int failures = 0;

   // reference-model state, written only by the checker process
   bit           m_busy = 1'b0;
   int           m_due  = 0;
   int           cyc    = 0;
   logic [W-1:0] m_q    = '0;
   logic [W-1:0] m_r    = '0;
   logic [W-1:0] p_q    = '0;
   logic [W-1:0] p_r    = '0;

   always #5 clk = ~clk;

   div_iter_unit dut (
      .clk          (clk),
      .reset        (reset),
      .div_start    (div_start),
      .div_signed   (div_signed),
      .div_a        (div_a),
      .div_b        (div_b),
      .div_cancel   (div_cancel),
      .div_complete (div_complete),
      .div_q        (div_q),
      .div_r        (div_r),
      .div_busy     (div_busy)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Truncating division on magnitudes; divide by zero gives all ones and the raw dividend
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      logic         na, nb;
      logic [W-1:0] ua, ub, uq, ur;
      if (b == '0) begin
         q = '1;
         r = a;
      end else begin
         na = sgn && a[W-1];
         nb = sgn && b[W-1];
         ua = na ? -a : a;
         ub = nb ? -b : b;
         uq = ua / ub;
         ur = ua % ub;
         q  = (na ^ nb) ? -uq : uq;
         r  = na ? -ur : ur;
      end
   endfunction

   // Cycle-level compare: check outputs mid-cycle, then advance the model with this cycle's inputs
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_busy = 1'b0;
            m_q    = '0;
            m_r    = '0;
         end
         chk("cyc_complete", W'(div_complete), W'(m_busy && cyc == m_due && !div_cancel));
         chk("cyc_busy", W'(div_busy), W'(m_busy));
         chk("cyc_q", div_q, m_q);
         chk("cyc_r", div_r, m_r);
         if (reset) begin
            if (m_busy) begin
               if (div_cancel || cyc == m_due) begin
                  m_busy = 1'b0;
               end else if (cyc + 1 == m_due) begin
                  m_q = p_q;
                  m_r = p_r;
               end
            end else if (div_start && !div_cancel) begin
               ref_div(div_a, div_b, div_signed, p_q, p_r);
               m_busy = 1'b1;
               m_due  = (FAST && (div_a == '0 || div_b == '0)) ? cyc + 1 : cyc + LAT;
               if (m_due == cyc + 1) begin
                  m_q = p_q;
                  m_r = p_r;
               end
            end
         end
         cyc++;
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      @(posedge clk);
      #2;
      div_a      = a;
      div_b      = b;
      div_signed = sgn;
      div_start  = 1'b1;
      div_cancel = 1'b0;
   endtask

   task automatic wait_done(input string name, input int lat, input logic [W-1:0] eq,
                            input logic [W-1:0] er);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 100) begin
         @(posedge clk);
         #2;
         n++;
         if (div_complete) done = 1'b1;
      end
      chk({name, "_lat"}, W'(n), W'(lat));
      chk({name, "_q"}, div_q, eq);
      chk({name, "_r"}, div_r, er);
      $display("txn %s: latency=%0d q=0x%08h r=0x%08h", name, n, div_q, div_r);
   endtask

   task automatic release_start();
      @(posedge clk);
      #2;
      div_start = 1'b0;
      chk("pulse_single", W'(div_complete), '0);
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", W'(div_busy), '0);
      chk("rst_complete", W'(div_complete), '0);
      chk("rst_q", div_q, '0);
      chk("rst_r", div_r, '0);
      reset = 1'b1;

      issue(32'd100, 32'd7, 1'b0);
      wait_done("divu_100_7", LAT, 32'd14, 32'd2);
      release_start();

      issue(32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done("div_m7_2", LAT, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      release_start();

      issue(32'd7, 32'hFFFF_FFFE, 1'b1);
      wait_done("div_7_m2", LAT, 32'hFFFF_FFFD, 32'd1);
      release_start();

      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done("div_min_m1", LAT, 32'h8000_0000, 32'd0);
      release_start();

      issue(32'd5, 32'd0, 1'b0);
      wait_done("divu_5_0", FAST ? 1 : LAT, 32'hFFFF_FFFF, 32'd5);
      release_start();

      issue(32'd0, 32'd9, 1'b0);
      wait_done("divu_0_9", FAST ? 1 : LAT, 32'd0, 32'd0);
      release_start();

      issue(32'hFFFF_FFFB, 32'd0, 1'b1);
      wait_done("div_m5_0", FAST ? 1 : LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
      release_start();

      // kill mid-iteration: counter reaches 10 eleven cycles after the latch
      issue(32'd1000, 32'd3, 1'b0);
      repeat (11) begin
         @(posedge clk);
         #2;
      end
      div_cancel = 1'b1;
      div_start  = 1'b0;
      @(posedge clk);
      #2;
      div_cancel = 1'b0;
      chk("cancel_busy", W'(div_busy), '0);
      chk("cancel_q_hold", div_q, 32'hFFFF_FFFF);
      chk("cancel_r_hold", div_r, 32'hFFFF_FFFB);
      $display("txn cancel: busy=%0d q=0x%08h r=0x%08h", div_busy, div_q, div_r);

      issue(32'd9, 32'd3, 1'b0);
      wait_done("divu_9_3", LAT, 32'd3, 32'd0);
      release_start();

      // start and cancel together in IDLE must not latch
      @(posedge clk);
      #2;
      div_a      = 32'd50;
      div_b      = 32'd5;
      div_start  = 1'b1;
      div_cancel = 1'b1;
      @(posedge clk);
      #2;
      div_start  = 1'b0;
      div_cancel = 1'b0;
      chk("start_cancel_busy", W'(div_busy), '0);
      $display("txn start+cancel: busy=%0d", div_busy);

      // back-to-back with start held through DONE
      issue(32'd100, 32'd7, 1'b0);
      wait_done("b2b_first", LAT, 32'd14, 32'd2);
      issue(32'hFFFF_FF9C, 32'd7, 1'b1);
      wait_done("b2b_second", LAT, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
      release_start();

      // asynchronous reset mid-iteration
      issue(32'd77, 32'd5, 1'b0);
      repeat (5) begin
         @(posedge clk);
         #2;
      end
      reset = 1'b0;
      #1;
      chk("arst_busy", W'(div_busy), '0);
      chk("arst_complete", W'(div_complete), '0);
      chk("arst_q", div_q, '0);
      chk("arst_r", div_r, '0);
      $display("txn async reset: busy=%0d q=0x%08h r=0x%08h", div_busy, div_q, div_r);
      div_start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;

      issue(32'd100, 32'd7, 1'b0);
      wait_done("after_rst_100_7", LAT, 32'd14, 32'd2);
      release_start();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
